// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned num_groups(input int unsigned width, input int unsigned group);
    return width / group;
  endfunction

  // Legal configuration: whole number of groups, at least one group.
  function automatic bit width_ok(input int unsigned width, input int unsigned group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Input/output valid-ready streams of the pipelined adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_pipe_adder_group.sv
// One first-level lookahead group: flattened internal carries, sum, group P/G.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] i_p,
  input  logic [GROUP-1:0] i_g,
  input  logic             i_cin,
  output logic [GROUP-1:0] o_sum,
  output logic             o_p,
  output logic             o_g
);

  logic [GROUP-1:0] w_c;

  // Each carry is a sum of products over the group bits below it; no ripple.
  always_comb begin
    logic term;
    term = 1'b0;
    w_c  = '0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      term = i_cin;
      for (int unsigned j = 0; j < i; j++) term = term & i_p[j];
      w_c[i] = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = i_g[j];
        for (int unsigned k = j + 1; k < i; k++) term = term & i_p[k];
        w_c[i] = w_c[i] | term;
      end
    end
  end

  always_comb begin
    logic term;
    term = 1'b0;
    o_g  = 1'b0;
    for (int unsigned j = 0; j < GROUP; j++) begin
      term = i_g[j];
      for (int unsigned k = j + 1; k < GROUP; k++) term = term & i_p[k];
      o_g = o_g | term;
    end
  end

  assign o_p   = &i_p;
  assign o_sum = i_p ^ w_c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_pipe_adder_if.slave    bus
);

  localparam int unsigned NG = num_groups(WIDTH, GROUP);

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic             r_c0;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_c_msb;
  logic             w_ovf;

  assign w_s2_adv = !r_out_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  assign w_b_eff = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
  assign w_c0    = (bus.in_op == OP_SUB) ? 1'b1 : bus.in_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_c0       <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      r_p        <= bus.in_a ^ w_b_eff;
      r_g        <= bus.in_a & w_b_eff;
      r_c0       <= w_c0;
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .i_p   (r_p[gi*GROUP +: GROUP]),
      .i_g   (r_g[gi*GROUP +: GROUP]),
      .i_cin (w_gc[gi]),
      .o_sum (w_sum[gi*GROUP +: GROUP]),
      .o_p   (w_gp[gi]),
      .o_g   (w_gg[gi])
    );
  end

  // Second-level network: every group carry-in is a flat sum of products of group P/G.
  always_comb begin
    logic term;
    term = 1'b0;
    w_gc = '0;
    for (int unsigned k = 0; k <= NG; k++) begin
      term = r_c0;
      for (int unsigned j = 0; j < k; j++) term = term & w_gp[j];
      w_gc[k] = term;
      for (int unsigned j = 0; j < k; j++) begin
        term = w_gg[j];
        for (int unsigned m = j + 1; m < k; m++) term = term & w_gp[m];
        w_gc[k] = w_gc[k] | term;
      end
    end
  end

  // Carry into the MSB is recovered from its sum bit rather than exported by the group.
  assign w_cout  = w_gc[NG];
  assign w_c_msb = w_sum[WIDTH-1] ^ r_p[WIDTH-1];
  assign w_ovf   = w_c_msb ^ w_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      r_sum       <= w_sum;
      r_cout      <= w_cout;
      r_ovf       <= w_ovf;
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder at WIDTH=16, GROUP=4.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned G = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(W)) bus ();

  cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic op);
    logic [W:0]   full;
    logic [W-1:0] be;
    logic         c;
    res_t         r;
    be     = op ? ~b : b;
    c      = op ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_op     = OP_ADD;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b want all 0",
               bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    vec_t tv[4];
    tv[0] = '{16'h00FF, 16'h0001, 1'b0, OP_ADD, 16'h0100, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1};
    tv[3] = '{16'h0000, 16'h0000, 1'b1, OP_ADD, 16'h0001, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_a = tv[i].a; bus.in_b = tv[i].b; bus.in_cin = tv[i].cin; bus.in_op = tv[i].op;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL add_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL add_early_valid[%0d]: got %b want 0", i, bus.out_valid);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !==
          {1'b1, tv[i].sum, tv[i].cout, tv[i].ovf}) begin
        bad++;
        $display("FAIL add_result[%0d]: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b", i,
                 bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf,
                 tv[i].sum, tv[i].cout, tv[i].ovf);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_sub();
    vec_t tv[3];
    tv[0] = '{16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0};
    tv[1] = '{16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1};
    tv[2] = '{16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_a = tv[i].a; bus.in_b = tv[i].b; bus.in_cin = tv[i].cin; bus.in_op = tv[i].op;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !==
          {1'b1, tv[i].sum, tv[i].cout, tv[i].ovf}) begin
        bad++;
        $display("FAIL sub_result[%0d]: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b", i,
                 bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf,
                 tv[i].sum, tv[i].cout, tv[i].ovf);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] va[4];
    int   acc_n = 0;
    int   out_n = 0;
    logic acc, emit;
    res_t got, exp, held;
    va[0] = 16'h1111; va[1] = 16'h2F22; va[2] = 16'h8333; va[3] = 16'h4444;
    sb.delete();
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus.in_valid = (acc_n < 4);
      if (acc_n < 4) begin
        bus.in_a = va[acc_n]; bus.in_b = 16'h0F0F; bus.in_cin = 1'b1; bus.in_op = acc_n[0];
      end
      #1;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) begin
        sb.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_op));
        acc_n++;
      end
      @(negedge clk);
    end
    total++;
    if (acc_n != 2 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_stall: got accepts=%0d in_ready=%b want 2 and 0", acc_n, bus.in_ready);
    end
    held = '{bus.out_sum, bus.out_cout, bus.out_ovf};
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || {bus.out_sum, bus.out_cout, bus.out_ovf} !== held) begin
      bad++;
      $display("FAIL bp_hold: got v=%b %h/%b/%b want v=1 %h/%b/%b", bus.out_valid,
               bus.out_sum, bus.out_cout, bus.out_ovf, held.sum, held.cout, held.ovf);
    end
    for (int cyc = 0; cyc < 20 && out_n < 4; cyc++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = (acc_n < 4);
      if (acc_n < 4) begin
        bus.in_a = va[acc_n]; bus.in_b = 16'h0F0F; bus.in_cin = 1'b1; bus.in_op = acc_n[0];
      end
      #1;
      acc  = bus.in_valid && bus.in_ready;
      emit = bus.out_valid && bus.out_ready;
      got  = '{bus.out_sum, bus.out_cout, bus.out_ovf};
      @(posedge clk);
      if (emit) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL bp_order[%0d]: got unexpected output %h want none", out_n, got.sum);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL bp_order[%0d]: got %h/%b/%b want %h/%b/%b", out_n,
                     got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
          end
        end
        out_n++;
      end
      if (acc) begin
        sb.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_op));
        acc_n++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    total++;
    if (out_n != 4 || acc_n != 4) begin
      bad++; $display("FAIL bp_count: got in=%0d out=%0d want 4 and 4", acc_n, out_n);
    end
  endtask

  task automatic test_stream();
    int   n_in = 0;
    int   n_out = 0;
    int   cyc = 0;
    logic acc, emit, pending;
    res_t got, exp;
    sb.delete();
    pending = 1'b0;
    @(negedge clk);
    while (n_out < 1000 && cyc < 20000) begin
      if (!pending) begin
        bus.in_valid = (n_in < 1000) && ($urandom_range(0, 3) != 0);
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        bus.in_cin   = 1'($urandom);
        bus.in_op    = 1'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc     = bus.in_valid && bus.in_ready;
      emit    = bus.out_valid && bus.out_ready;
      got     = '{bus.out_sum, bus.out_cout, bus.out_ovf};
      pending = bus.in_valid && !acc;
      @(posedge clk);
      if (emit) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL stream[%0d]: got unexpected output %h want none", n_out, got.sum);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL stream[%0d]: got %h/%b/%b want %h/%b/%b", n_out,
                     got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
          end
        end
        n_out++;
      end
      if (acc) begin
        sb.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_op));
        n_in++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    total++;
    if (n_in != 1000 || n_out != 1000) begin
      bad++; $display("FAIL stream_count: got in=%0d out=%0d want 1000 and 1000", n_in, n_out);
    end
  endtask

  task automatic test_reset_midflight();
    int   n = 0;
    int   stale = 0;
    logic acc;
    sb.delete();
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 10 && n < 2; cyc++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 16'h7FFF; bus.in_b = 16'h0001; bus.in_cin = 1'b0; bus.in_op = OP_ADD;
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (n != 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== 16'h8000) begin
      bad++;
      $display("FAIL full_state: got accepts=%0d in_ready=%b v=%b s=%h want 2 0 1 8000",
               n, bus.in_ready, bus.out_valid, bus.out_sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !== '0) begin
      bad++;
      $display("FAIL async_reset: got v=%b s=%h c=%b o=%b want all 0",
               bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_ready: got %b want 1", bus.in_ready);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL post_reset_stale: got %0d stale outputs want 0", stale);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_stream();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
